// File: rtl/sparse_chunk_streamer.sv
// Compresses dense byte beats into a sparse map plus packed nonzero bytes per chunk, then streams the chunk out.
// Optional build macro SPARSE_STREAM_PRUNE_EN: bytes <= PRUNE_THRESHOLD are treated as zero.
module sparse_chunk_streamer #(
  parameter int unsigned CHUNK_SIZE      = 128,
  parameter int unsigned BUS_SIZE        = 8,
  parameter logic [7:0]  PRUNE_THRESHOLD = 8'd0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [BUS_SIZE*8-1:0]                 dense_data_i,
  input  logic                                  dense_valid_i,
  output logic                                  dense_ready_o,
  input  logic                                  send_en_i,
  output logic [BUS_SIZE-1:0]                   sparsemap_o,
  output logic [BUS_SIZE*8-1:0]                 nonzero_data_o,
  output logic                                  chunk_wr_valid_o,
  output logic [$clog2(CHUNK_SIZE/BUS_SIZE)-1:0] chunk_wr_count_o,
  output logic                                  chunk_wr_sel_o,
  output logic [$clog2(CHUNK_SIZE):0]           nonzero_cnt_o,
  output logic                                  chunk_done_o
);

  localparam int unsigned BEATS = CHUNK_SIZE / BUS_SIZE;
  localparam int unsigned CW    = $clog2(BEATS);
  localparam int unsigned AW    = $clog2(CHUNK_SIZE);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned SW    = CW + 1;

  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [SW-1:0] SEND_END  = SW'(BEATS);

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  logic [1:0]            r_state;
  logic                  r_ready;
  logic [CW-1:0]         r_beat;
  logic [PW-1:0]         r_ptr;
  logic [SW-1:0]         r_sidx;
  logic [PW-1:0]         r_nzcnt;
  logic                  r_valid;
  logic [CW-1:0]         r_count;
  logic                  r_sel;
  logic [BUS_SIZE-1:0]   r_map_o;
  logic [BUS_SIZE*8-1:0] r_data_o;
  logic                  r_done;

  logic [BUS_SIZE-1:0]   r_map    [BEATS];
  logic [7:0]            r_packed [CHUNK_SIZE];

  logic [BUS_SIZE-1:0]   w_map_nxt    [BEATS];
  logic [7:0]            w_packed_nxt [CHUNK_SIZE];
  logic [PW-1:0]         w_ptr_nxt;
  logic [BUS_SIZE-1:0]   w_nz;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_enter_send;
  logic                  w_send_end;
  logic                  w_load;
  logic [CW-1:0]         w_ld_beat;
  logic [BUS_SIZE-1:0]   w_slice_map;
  logic [BUS_SIZE*8-1:0] w_slice_data;

`ifdef SPARSE_STREAM_PRUNE_EN
  always_comb begin
    w_nz = '0;
    for (int unsigned k = 0; k < BUS_SIZE; k++)
      w_nz[k] = (dense_data_i[k*8 +: 8] > PRUNE_THRESHOLD);
  end
`else
  logic [7:0] w_unused_thr;
  assign w_unused_thr = PRUNE_THRESHOLD;

  always_comb begin
    w_nz = '0;
    for (int unsigned k = 0; k < BUS_SIZE; k++)
      w_nz[k] = (dense_data_i[k*8 +: 8] != 8'h00);
  end
`endif

  // r_ready is only ever high in FILL, so it doubles as the state qualifier
  assign w_accept     = r_ready & dense_valid_i;
  assign w_last       = w_accept & (r_beat == LAST_BEAT);
  assign w_enter_send = ((r_state == S_FILL) & w_last & send_en_i) |
                        ((r_state == S_HOLD) & send_en_i);
  assign w_send_end   = (r_state == S_SEND) & (r_sidx == SEND_END);
  assign w_load       = w_enter_send | ((r_state == S_SEND) & ~w_send_end);
  assign w_ld_beat    = (r_state == S_SEND) ? r_sidx[CW-1:0] : '0;

  // Next-state image of map/buffer, so beat 0 can be launched on the same edge as the final fill write
  always_comb begin
    logic [PW-1:0] v_off;
    v_off        = '0;
    w_map_nxt    = r_map;
    w_packed_nxt = r_packed;
    if (w_accept) begin
      w_map_nxt[r_beat] = w_nz;
      for (int unsigned k = 0; k < BUS_SIZE; k++) begin
        if (w_nz[k]) begin
          w_packed_nxt[AW'(r_ptr + v_off)] = dense_data_i[k*8 +: 8];
          v_off = v_off + PW'(1);
        end
      end
    end
    w_ptr_nxt = r_ptr + v_off;
  end

  always_comb begin
    w_slice_map  = w_map_nxt[w_ld_beat];
    w_slice_data = '0;
    for (int unsigned k = 0; k < BUS_SIZE; k++)
      w_slice_data[k*8 +: 8] = w_packed_nxt[AW'(int'(w_ld_beat) * BUS_SIZE + k)];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_FILL;
      r_ready  <= 1'b0;
      r_beat   <= '0;
      r_ptr    <= '0;
      r_sidx   <= '0;
      r_nzcnt  <= '0;
      r_valid  <= 1'b0;
      r_count  <= '0;
      r_sel    <= 1'b0;
      r_map_o  <= '0;
      r_data_o <= '0;
      r_done   <= 1'b0;
      for (int unsigned i = 0; i < BEATS; i++)      r_map[i]    <= '0;
      for (int unsigned i = 0; i < CHUNK_SIZE; i++) r_packed[i] <= '0;
    end else begin
      r_done <= 1'b0;

      if (w_load) begin
        r_valid  <= 1'b1;
        r_count  <= w_ld_beat;
        r_map_o  <= w_slice_map;
        r_data_o <= w_slice_data;
        r_sidx   <= {1'b0, w_ld_beat} + SW'(1);
      end

      case (r_state)
        S_FILL: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_map    <= w_map_nxt;
            r_packed <= w_packed_nxt;
            r_ptr    <= w_ptr_nxt;
            r_beat   <= r_beat + 1'b1;
            if (w_last) begin
              r_beat  <= '0;
              r_ready <= 1'b0;
              r_nzcnt <= w_ptr_nxt;
              r_state <= send_en_i ? S_SEND : S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (send_en_i) r_state <= S_SEND;
        end

        S_SEND: begin
          if (w_send_end) begin
            r_state  <= S_FILL;
            r_ready  <= 1'b1;
            r_ptr    <= '0;
            r_sidx   <= '0;
            r_valid  <= 1'b0;
            r_count  <= '0;
            r_map_o  <= '0;
            r_data_o <= '0;
            r_done   <= 1'b1;
            r_sel    <= ~r_sel;
            for (int unsigned i = 0; i < BEATS; i++)      r_map[i]    <= '0;
            for (int unsigned i = 0; i < CHUNK_SIZE; i++) r_packed[i] <= '0;
          end
        end

        default: begin
          r_state <= S_FILL;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign dense_ready_o    = r_ready;
  assign sparsemap_o      = r_map_o;
  assign nonzero_data_o   = r_data_o;
  assign chunk_wr_valid_o = r_valid;
  assign chunk_wr_count_o = r_count;
  assign chunk_wr_sel_o   = r_sel;
  assign nonzero_cnt_o    = r_nzcnt;
  assign chunk_done_o     = r_done;

endmodule

// File: tb/tb_sparse_chunk_streamer.sv
// Directed self-checking bench for sparse_chunk_streamer (128-byte chunks, 8-byte beats, threshold 10).
module tb_sparse_chunk_streamer;

  localparam int unsigned NB = 16;

`ifdef SPARSE_STREAM_PRUNE_EN
  localparam logic [7:0]  V30_MAP  = 8'h00;
  localparam logic [63:0] V30_DATA = 64'h0;
  localparam logic [7:0]  V30_CNT  = 8'd0;
  localparam logic [7:0]  P_MAP0   = 8'h0A;
  localparam logic [63:0] P_DATA0  = 64'h2222_2222_2222_FF0B;
  localparam logic [63:0] P_DATA1  = 64'h0000_0000_0011_2222;
  localparam logic [7:0]  P_CNT    = 8'd11;
`else
  localparam logic [7:0]  V30_MAP  = 8'h8A;
  localparam logic [63:0] V30_DATA = 64'h0000_0000_0009_0705;
  localparam logic [7:0]  V30_CNT  = 8'd3;
  localparam logic [7:0]  P_MAP0   = 8'h0B;
  localparam logic [63:0] P_DATA0  = 64'h2222_2222_22FF_0B0A;
  localparam logic [63:0] P_DATA1  = 64'h0000_0000_1122_2222;
  localparam logic [7:0]  P_CNT    = 8'd12;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] dense_data;
  logic        dense_valid;
  logic        dense_ready;
  logic        send_en;
  logic [7:0]  sparsemap;
  logic [63:0] nonzero_data;
  logic        wr_valid;
  logic [3:0]  wr_count;
  logic        wr_sel;
  logic [7:0]  nz_cnt;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] d      [NB];
  logic [7:0]  e_map  [NB];
  logic [63:0] e_data [NB];

  always #5 clk = ~clk;

  sparse_chunk_streamer #(
    .CHUNK_SIZE     (128),
    .BUS_SIZE       (8),
    .PRUNE_THRESHOLD(8'd10)
  ) u_dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .dense_data_i    (dense_data),
    .dense_valid_i   (dense_valid),
    .dense_ready_o   (dense_ready),
    .send_en_i       (send_en),
    .sparsemap_o     (sparsemap),
    .nonzero_data_o  (nonzero_data),
    .chunk_wr_valid_o(wr_valid),
    .chunk_wr_count_o(wr_count),
    .chunk_wr_sel_o  (wr_sel),
    .nonzero_cnt_o   (nz_cnt),
    .chunk_done_o    (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_vectors();
    for (int i = 0; i < NB; i++) begin
      d[i]      = '0;
      e_map[i]  = '0;
      e_data[i] = '0;
    end
  endtask

  task automatic set_all_ff();
    for (int i = 0; i < NB; i++) begin
      d[i]      = '1;
      e_map[i]  = 8'hFF;
      e_data[i] = '1;
    end
  endtask

  // Garbage data is driven during valid gaps; it must never be absorbed.
  task automatic feed_chunk(input logic en, input logic gaps);
    send_en = en;
    for (int i = 0; i < NB; i++) begin
      if (gaps && (i % 3 == 1)) begin
        dense_valid = 1'b0;
        dense_data  = 64'hDEAD_BEEF_0102_0304;
        tick();
      end
      chk("fill_ready", dense_ready, 1);
      dense_data  = d[i];
      dense_valid = 1'b1;
      tick();
    end
    dense_valid = 1'b0;
    dense_data  = '0;
  endtask

  task automatic check_burst(input logic [7:0] ecnt, input logic esel);
    chk("nz_cnt", nz_cnt, ecnt);
    for (int i = 0; i < NB; i++) begin
      chk("burst_valid", wr_valid, 1);
      chk("burst_count", wr_count, i);
      chk("burst_map", sparsemap, e_map[i]);
      chk("burst_data", nonzero_data, e_data[i]);
      chk("burst_sel", wr_sel, esel);
      chk("burst_ready", dense_ready, 0);
      chk("burst_done", done, 0);
      tick();
    end
    chk("end_valid", wr_valid, 0);
    chk("end_count", wr_count, 0);
    chk("end_done", done, 1);
    chk("end_sel", wr_sel, !esel);
    chk("end_ready", dense_ready, 1);
    tick();
    chk("done_pulse", done, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, wr_valid, 0);
    chk({tag, "_count"}, wr_count, 0);
    chk({tag, "_sel"}, wr_sel, 0);
    chk({tag, "_map"}, sparsemap, 0);
    chk({tag, "_data"}, nonzero_data, 0);
    chk({tag, "_cnt"}, nz_cnt, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ready"}, dense_ready, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    dense_data  = '0;
    dense_valid = 1'b0;
    send_en     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    chk("ready_before_clock", dense_ready, 0);
    tick();
    chk("ready_after_clock", dense_ready, 1);

    // Chunk held back by send_en low, then released
    clr_vectors();
    d[0]      = 64'h0900_0000_0700_0500;
    e_map[0]  = V30_MAP;
    e_data[0] = V30_DATA;
    feed_chunk(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("hold_valid", wr_valid, 0);
      chk("hold_ready", dense_ready, 0);
      tick();
    end
    send_en = 1'b1;
    tick();
    send_en = 1'b0;
    check_burst(V30_CNT, 1'b0);

    // All-zero chunk
    clr_vectors();
    feed_chunk(1'b1, 1'b0);
    send_en = 1'b0;
    check_burst(8'd0, 1'b1);

    // All-FF chunk: pointer must reach 128 without wrapping
    set_all_ff();
    feed_chunk(1'b1, 1'b0);
    send_en = 1'b0;
    check_burst(8'd128, 1'b0);

    // Reset in the middle of a burst
    set_all_ff();
    feed_chunk(1'b1, 1'b0);
    send_en = 1'b0;
    repeat (7) tick();
    chk("pre_abort_count", wr_count, 7);
    chk("pre_abort_sel", wr_sel, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort_ready", dense_ready, 1);
    chk("abort_valid", wr_valid, 0);

    clr_vectors();
    d[0]      = 64'h0900_0000_0700_0500;
    e_map[0]  = V30_MAP;
    e_data[0] = V30_DATA;
    feed_chunk(1'b1, 1'b0);
    send_en = 1'b0;
    check_burst(V30_CNT, 1'b0);

    // Threshold bytes and packing across beat boundaries, with valid gaps
    clr_vectors();
    d[0]      = 64'h0000_0000_FF00_0B0A;
    d[1]      = 64'h2222_2222_2222_2222;
    d[2]      = 64'h0000_0000_0000_0011;
    e_map[0]  = P_MAP0;
    e_map[1]  = 8'hFF;
    e_map[2]  = 8'h01;
    e_data[0] = P_DATA0;
    e_data[1] = P_DATA1;
    feed_chunk(1'b1, 1'b1);
    send_en = 1'b0;
    check_burst(P_CNT, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
